// File: rtl/sha3_pkg.sv
// Shared constants, state encoding and byte-count helper for the SHA3-256 padder.
package sha3_pkg;

   localparam int RATE_BYTES = 136;
   localparam int RATE_WORDS = 17;
   localparam logic [7:0] SHA3_DSUFFIX = 8'h06;
   localparam logic [7:0] SHA3_PAD_END = 8'h80;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_ACK   = 2'd2,
      ST_PAD   = 2'd3
   } sha3_state_e;

   // Non-final words are always full; out-of-range counts saturate at a full word.
   function automatic logic [3:0] eff_bytes(input logic [3:0] nbytes, input logic last);
      logic [3:0] r;
      if (!last) begin
         r = 4'd8;
      end else if (nbytes > 4'd8) begin
         r = 4'd8;
      end else begin
         r = nbytes;
      end
      return r;
   endfunction

endpackage

// File: rtl/sha3_tail_pad.sv
// Final-word masking: keeps the valid bytes, zeroes the rest and places the
// domain suffix in the first unused byte when one exists.
module sha3_tail_pad
   import sha3_pkg::*;
(
   input  logic [63:0] word,
   input  logic [3:0]  in_bytes,
   output logic [63:0] word_out,
   output logic        sfx_in_word
);

   // byte 0 sits in the top lane, so lane i covers [63-8i -: 8]
   always_comb begin
      word_out = 64'd0;
      for (int i = 0; i < 8; i++) begin
         if (4'(i) < in_bytes) begin
            word_out[63-8*i -: 8] = word[63-8*i -: 8];
         end else if (4'(i) == in_bytes) begin
            word_out[63-8*i -: 8] = SHA3_DSUFFIX;
         end else begin
            word_out[63-8*i -: 8] = 8'd0;
         end
      end
   end

   assign sfx_in_word = (in_bytes < 4'd8);

endmodule

// File: rtl/sha3_padder.sv
// Packs 64-bit message words into SHA3-256 rate blocks, applies pad10*1 with the
// 0x06 domain suffix and hands each block to the hash core with a start pulse.
module sha3_padder #(
   parameter int RATE_BYTES = sha3_pkg::RATE_BYTES
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [63:0]             in_data,
   input  logic                    in_valid,
   input  logic                    in_last,
   input  logic [3:0]              in_bytes,
   output logic                    in_ready,
   output logic [RATE_BYTES*8-1:0] blk_data,
   output logic                    blk_start,
   output logic                    blk_is_last,
   input  logic                    core_ready
);
   import sha3_pkg::*;

   localparam int BLK_W = RATE_BYTES * 8;
   localparam logic [BLK_W-1:0] PAD_BLK = {SHA3_DSUFFIX, {(BLK_W-16){1'b0}}, SHA3_PAD_END};

   sha3_state_e      state_r, state_d;
   logic [4:0]       word_cnt_r, word_cnt_d;
   logic             pad_pend_r, pad_pend_d;
   logic [BLK_W-1:0] blk_r, blk_d;
   logic             last_r, last_d;
   logic             start_r, start_d;
   logic             ready_r, ready_d;

   logic             accept_s;
   logic [3:0]       nbytes_s;
   logic [63:0]      tail_word_s;
   logic             sfx_in_word_s;
   logic [7:0]       p_s;
   logic [10:0]      slot_base_s;

   assign accept_s    = in_valid & ready_r;
   assign nbytes_s    = eff_bytes(in_bytes, in_last);
   assign p_s         = {word_cnt_r, 3'b000} + {4'd0, nbytes_s};
   assign slot_base_s = 11'(BLK_W - 1) - {word_cnt_r, 6'b000000};

   sha3_tail_pad u_tail_pad (
      .word        (in_data),
      .in_bytes    (nbytes_s),
      .word_out    (tail_word_s),
      .sfx_in_word (sfx_in_word_s)
   );

   // next-state, block assembly and output intent
   always_comb begin
      state_d    = state_r;
      word_cnt_d = word_cnt_r;
      pad_pend_d = pad_pend_r;
      blk_d      = blk_r;
      last_d     = last_r;
      start_d    = 1'b0;
      case (state_r)
         ST_FILL: begin
            if (accept_s) begin
               blk_d[slot_base_s -: 64] = tail_word_s;
               if (in_last) begin
                  state_d = ST_ISSUE;
                  if (p_s == 8'(RATE_BYTES)) begin
                     pad_pend_d = 1'b1;
                     last_d     = 1'b0;
                  end else begin
                     last_d = 1'b1;
                     // a full last word pushes the suffix into byte 0 of the next slot
                     if (sfx_in_word_s) begin
                        blk_d[7:0] = blk_d[7:0] ^ SHA3_PAD_END;
                     end else begin
                        blk_d[slot_base_s - 11'd64 -: 8] = SHA3_DSUFFIX;
                        blk_d[7:0] = blk_d[7:0] ^ SHA3_PAD_END;
                     end
                  end
               end else if (word_cnt_r == 5'(RATE_WORDS - 1)) begin
                  word_cnt_d = 5'd0;
                  last_d     = 1'b0;
                  state_d    = ST_ISSUE;
               end else begin
                  word_cnt_d = word_cnt_r + 5'd1;
               end
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_ISSUE: begin
            if (core_ready) begin
               start_d = 1'b1;
               state_d = ST_ACK;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_ACK: begin
            // core_ready dropping marks the core's absorb cycle; the block is free after it
            if (!core_ready) begin
               blk_d      = {BLK_W{1'b0}};
               word_cnt_d = 5'd0;
               last_d     = 1'b0;
               state_d    = pad_pend_r ? ST_PAD : ST_FILL;
            end else begin
               state_d = ST_ACK;
            end
         end
         ST_PAD: begin
            blk_d      = PAD_BLK;
            last_d     = 1'b1;
            pad_pend_d = 1'b0;
            state_d    = ST_ISSUE;
         end
         default: begin
            state_d    = ST_FILL;
            word_cnt_d = 5'd0;
            pad_pend_d = 1'b0;
            blk_d      = {BLK_W{1'b0}};
            last_d     = 1'b0;
         end
      endcase
      ready_d = (state_d == ST_FILL);
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_FILL;
         word_cnt_r <= 5'd0;
         pad_pend_r <= 1'b0;
         blk_r      <= {BLK_W{1'b0}};
         last_r     <= 1'b0;
         start_r    <= 1'b0;
         ready_r    <= 1'b0;
      end else begin
         state_r    <= state_d;
         word_cnt_r <= word_cnt_d;
         pad_pend_r <= pad_pend_d;
         blk_r      <= blk_d;
         last_r     <= last_d;
         start_r    <= start_d;
         ready_r    <= ready_d;
      end
   end

   assign in_ready    = ready_r;
   assign blk_data    = blk_r;
   assign blk_start   = start_r;
   assign blk_is_last = last_r;

endmodule

// File: tb/tb_sha3_padder.sv
// Scoreboard bench for sha3_padder: expected padded blocks are built from the
// message bytes with plain pad10*1 and compared when blk_start pulses.
module tb_sha3_padder;

   localparam int RB = 136;
   localparam int BW = RB * 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [63:0]   in_data = 64'd0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic [3:0]    in_bytes = 4'd0;
   logic          in_ready;
   logic [BW-1:0] blk_data;
   logic          blk_start;
   logic          blk_is_last;
   logic          core_ready;

   typedef struct {
      logic [BW-1:0] data;
      logic          last;
   } blk_t;

   blk_t         exp_q[$];
   int           total = 0;
   int           bad = 0;
   int           n_start = 0;
   logic         prev_start = 1'b0;
   byte unsigned msg[0:299];
   int           msg_len = 0;
   logic         hold_core = 1'b0;
   int           busy = 0;

   sha3_padder #(.RATE_BYTES(RB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_bytes    (in_bytes),
      .in_ready    (in_ready),
      .blk_data    (blk_data),
      .blk_start   (blk_start),
      .blk_is_last (blk_is_last),
      .core_ready  (core_ready)
   );

   always #5 clk = ~clk;

   // simple core: busy for a few cycles after each start pulse
   assign core_ready = rst_n && !hold_core && (busy == 0);
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= 0;
      else if (blk_start) busy <= 3;
      else if (busy > 0) busy <= busy - 1;
   end

   // scoreboard monitor
   always @(negedge clk) begin
      blk_t e;
      int   j;
      if (blk_start) begin
         n_start++;
         total++;
         if (prev_start) begin
            bad++;
            $display("FAIL start_width: blk_start high two cycles running, required one");
         end
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_block: got start with no block expected, is_last=%0b", blk_is_last);
         end else begin
            e = exp_q.pop_front();
            if (blk_data !== e.data) begin
               j = 0;
               while (j < RB - 1 && blk_data[BW-1-8*j -: 8] === e.data[BW-1-8*j -: 8]) j++;
               bad++;
               $display("FAIL blk_data: byte %0d got %02h required %02h", j,
                        blk_data[BW-1-8*j -: 8], e.data[BW-1-8*j -: 8]);
            end
            total++;
            if (blk_is_last !== e.last) begin
               bad++;
               $display("FAIL blk_is_last: got %0b required %0b", blk_is_last, e.last);
            end
         end
      end
      prev_start <= blk_start;
   end

   task automatic push_expected();
      int           nblk;
      byte unsigned pb[0:407];
      blk_t         e;
      nblk = msg_len / RB + 1;
      for (int i = 0; i < nblk * RB; i++) pb[i] = (i < msg_len) ? msg[i] : 8'h00;
      pb[msg_len] = pb[msg_len] ^ 8'h06;
      pb[nblk*RB-1] = pb[nblk*RB-1] ^ 8'h80;
      for (int b = 0; b < nblk; b++) begin
         for (int k = 0; k < RB; k++) e.data[BW-1-8*k -: 8] = pb[b*RB+k];
         e.last = (b == nblk - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic random_msg(input int len);
      msg_len = len;
      for (int i = 0; i < len; i++) msg[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic send_msg(input int max_words);
      int nw;
      nw = (msg_len == 0) ? 1 : (msg_len + 7) / 8;
      for (int w = 0; w < nw && w < max_words; w++) begin
         int          nb;
         int          cnt;
         logic [63:0] d;
         nb = (w == nw - 1) ? msg_len - 8 * w : 8;
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom};
            in_last  = 1'b1;
            in_bytes = 4'($urandom_range(0, 15));
            @(negedge clk);
         end
         d = {$urandom, $urandom};
         for (int k = 0; k < nb; k++) d[63-8*k -: 8] = msg[8*w+k];
         in_data  = d;
         in_valid = 1'b1;
         in_last  = (w == nw - 1);
         if (w != nw - 1) in_bytes = 4'($urandom_range(0, 15));
         else if (nb == 8) in_bytes = 4'($urandom_range(8, 15));
         else in_bytes = 4'(nb);
         cnt = 0;
         while (!in_ready && cnt < 1000) begin
            @(negedge clk);
            cnt++;
         end
         total++;
         if (cnt >= 1000) begin
            bad++;
            $display("FAIL in_ready_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, cnt);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int cnt;
      cnt = 0;
      while ((exp_q.size() != 0 || !in_ready) && cnt < 2000) begin
         @(negedge clk);
         cnt++;
      end
      total++;
      if (cnt >= 2000) begin
         bad++;
         $display("FAIL drain_timeout: %0d blocks still expected, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %0b required 0", in_ready); end
      total++;
      if (blk_start !== 1'b0) begin bad++; $display("FAIL reset_blk_start: got %0b required 0", blk_start); end
      total++;
      if (blk_is_last !== 1'b0) begin bad++; $display("FAIL reset_blk_is_last: got %0b required 0", blk_is_last); end
      total++;
      if (blk_data !== {BW{1'b0}}) begin bad++; $display("FAIL reset_blk_data: got nonzero required 0"); end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %0b required 1", in_ready); end
      @(negedge clk);
   endtask

   task automatic test_empty();
      msg_len = 0;
      push_expected();
      send_msg(99);
      drain();
   endtask

   task automatic test_abc();
      msg_len = 3;
      msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
      push_expected();
      send_msg(99);
      drain();
   endtask

   task automatic test_len135();
      random_msg(135);
      push_expected();
      send_msg(99);
      drain();
   endtask

   task automatic test_len136();
      int s0;
      s0 = n_start;
      random_msg(136);
      push_expected();
      send_msg(99);
      drain();
      total++;
      if (n_start - s0 !== 2) begin
         bad++;
         $display("FAIL len136_starts: got %0d start pulses required 2", n_start - s0);
      end
   endtask

   task automatic test_back_to_back();
      int lens[10] = '{1, 7, 8, 9, 64, 128, 134, 137, 200, 272};
      foreach (lens[i]) begin
         random_msg(lens[i]);
         push_expected();
         send_msg(99);
      end
      drain();
   endtask

   task automatic test_stall();
      logic [BW-1:0] snap;
      hold_core = 1'b1;
      random_msg(21);
      push_expected();
      send_msg(99);
      snap = blk_data;
      for (int c = 0; c < 40; c++) begin
         total++;
         if (blk_start !== 1'b0) begin bad++; $display("FAIL stall_start: cycle %0d got %0b required 0", c, blk_start); end
         total++;
         if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready: cycle %0d got %0b required 0", c, in_ready); end
         total++;
         if (blk_data !== snap) begin bad++; $display("FAIL stall_data: cycle %0d block changed, required stable", c); end
         @(negedge clk);
      end
      hold_core = 1'b0;
      drain();
   endtask

   task automatic test_midreset();
      random_msg(48);
      send_msg(5);
      rst_n = 1'b0;
      #2;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL midreset_in_ready: got %0b required 0", in_ready); end
      total++;
      if (blk_data !== {BW{1'b0}}) begin bad++; $display("FAIL midreset_blk_data: got nonzero required 0"); end
      total++;
      if (blk_start !== 1'b0 || blk_is_last !== 1'b0) begin
         bad++;
         $display("FAIL midreset_flags: start=%0b last=%0b required 0 0", blk_start, blk_is_last);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready: got %0b required 1", in_ready); end
      test_abc();
   endtask

   initial begin
      test_reset();
      test_empty();
      test_abc();
      test_len135();
      test_len136();
      test_back_to_back();
      test_stall();
      test_midreset();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_blocks: got %0d required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sha3_padder.md
SHA3_PADDER -- requirements
Module: sha3_padder

Interface
REQ-001 SHALL have parameter RATE_BYTES, default 136, meaning SHA3-256 rate in bytes; fixed to 136 in this release.
REQ-002 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_data  input  64  message word; byte 0 of the word in [63:56].
REQ-005 SHALL have port in_valid  input  1  in_data/in_last/in_bytes valid.
REQ-006 SHALL have port in_last  input  1  final word of message.
REQ-007 SHALL have port in_bytes  input  4  valid byte count of the final word, 0..8; ignored (taken as 8) when in_last=0; values 9..15 taken as 8.
REQ-008 SHALL have port in_ready  output  1  word accepted when in_valid&in_ready at the clock edge.
REQ-009 SHALL have port blk_data  output  1088  padded rate block; block byte 0 in [1087:1080], byte 135 in [7:0].
REQ-010 SHALL have port blk_start  output  1  one-cycle request to the hash core.
REQ-011 SHALL have port blk_is_last  output  1  block is the final block of its message.
REQ-012 SHALL have port core_ready  input  1  hash core idle and able to take a block.

Function
REQ-013 SHALL implement states FILL, ISSUE, ACK, PAD; all outputs registered.
REQ-014 SHALL, in FILL, drive in_ready=1, write each accepted word into word slot word_cnt (0..16), increment word_cnt; bytes beyond in_bytes in the last word are zeroed.
REQ-015 SHALL, on accepting a non-last word at word_cnt=16, go to ISSUE with blk_is_last=0 and word_cnt wrapped to 0.
REQ-016 SHALL, on accepting a last word, compute p = 8*word_cnt + in_bytes; if p<136, XOR 0x06 into byte p and 0x80 into byte 135 (p=135 gives 0x86), blk_is_last=1, go to ISSUE.
REQ-017 SHALL, if p=136, issue the data block with blk_is_last=0 and set pad_pending.
REQ-018 SHALL drive in_ready=0 in ISSUE, ACK, PAD, including the cycle after the accepting edge.
REQ-019 SHALL, in ISSUE, pulse blk_start for exactly one cycle in the first cycle core_ready=1, then go to ACK; with core_ready=0 it waits indefinitely.
REQ-020 SHALL hold blk_data and blk_is_last stable from entry to ISSUE until the edge at which ACK observes core_ready=0 (the core's absorb cycle).
REQ-021 SHALL, on that edge, clear the block register and word_cnt and go to PAD if pad_pending, else FILL.
REQ-022 SHALL, in PAD (one cycle), load a block with byte 0=0x06, bytes 1..134=0x00, byte 135=0x80, blk_is_last=1, clear pad_pending, go to ISSUE.
REQ-023 SHALL support empty message (in_last, in_bytes=0 at word_cnt=0) as a single pad-only block.
REQ-024 SHALL ignore in_data/in_last/in_bytes when in_valid=0; never drop or duplicate an accepted word.

Reset
REQ-025 SHALL, while rst_n=0, hold state=FILL, word_cnt=0, pad_pending=0, blk_data=0, blk_start=0, blk_is_last=0, in_ready=0.
REQ-026 SHALL assert in_ready=1 on the first clock edge after rst_n deasserts.
REQ-027 SHALL discard any partial block or pending request on reset mid-operation; the core shares rst_n.

Structure
REQ-028 SHALL take RATE_BYTES=136, RATE_WORDS=17, SHA3_DSUFFIX=8'h06, SHA3_PAD_END=8'h80 and the state encoding from shared package sha3_pkg.
REQ-029 SHALL place the final-word masking and 0x06 insertion in one combinational sub-module sha3_tail_pad (inputs word, in_bytes; output masked word plus suffix-position flag).

Verification
REQ-030 SHALL cover empty message -> one block 06 00..00 80, blk_is_last=1; with the core attached, hash a7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a.
REQ-031 SHALL cover "abc" (in_data=0x616263xx.., in_bytes=3, last) -> bytes 61 62 63 06 .. 80; hash 3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532.
REQ-032 SHALL cover 135-byte message (17th word in_bytes=7) -> single block, byte 135=0x86, blk_is_last=1.
REQ-033 SHALL cover 136-byte message -> data block with blk_is_last=0, then pad-only block with blk_is_last=1, exactly two blk_start pulses.
REQ-034 SHALL cover core_ready held 0 for 40 cycles in ISSUE -> blk_start=0, blk_data unchanged, in_ready=0 throughout.
REQ-035 SHALL cover rst_n pulse after 5 accepted words -> all outputs at reset values; next "abc" message produces the REQ-031 hash.
